race_lights_controller: RTL and testbench
=========================================

Name: race_lights_controller

Overview:
Drag-race "Christmas tree" light sequencer. When START is asserted, it steps RED → YELLOW → GREEN with fixed, parameterised dwell times, then holds GREEN until START is released. It is a standalone FSM driving three lamp outputs, sitting between the start-button conditioning logic and the lamp drivers.

Parameters:
RED_CYCLES, 2, clock cycles RED is lit per sequence (legal range ≥1)
YELLOW_CYCLES, 2, clock cycles YELLOW is lit per sequence (legal range ≥1)
CNT_W, 8, dwell counter width; must satisfy 2^CNT_W > max(RED_CYCLES, YELLOW_CYCLES)

Ports:
CLOCK  input  1  single clock, rising-edge active
Reset  input  1  synchronous, active-high reset
START  input  1  level request to run the light sequence, synchronous to CLOCK
RED    output 1  red lamp, registered
YELLOW output 1  yellow lamp, registered
GREEN  output 1  green lamp, registered

Behaviour:
- One clock; reset is synchronous and active-high: Reset sampled high at a CLOCK rising edge → state IDLE, counter 0, RED=YELLOW=GREEN=0. Reset overrides START and applies mid-sequence.
- States: IDLE, S_RED, S_YELLOW, S_GREEN. Binary-encoded; outputs decoded from the state register only (no combinational path from START to outputs).
- Output map: IDLE 000, S_RED RED=1, S_YELLOW YELLOW=1, S_GREEN GREEN=1. At most one lamp is lit in any cycle.
- IDLE: START=1 at an edge → S_RED at that edge, counter cleared. START=0 → stay IDLE.
- S_RED: counter increments each edge. When counter = RED_CYCLES-1 → S_YELLOW, counter cleared. RED is high for exactly RED_CYCLES cycles.
- S_YELLOW: same rule with YELLOW_CYCLES → S_GREEN.
- S_GREEN: stays while START=1. START=0 at an edge → IDLE at that edge.
- START behaviour during S_RED and S_YELLOW depends on the optional feature; by default it is ignored there.
- Latency: START sampled high in IDLE at edge k → RED visible after edge k; YELLOW after edge k+RED_CYCLES; GREEN after edge k+RED_CYCLES+YELLOW_CYCLES.
- Re-arm: a new sequence starts only from IDLE. START held continuously after GREEN keeps GREEN lit and does not restart.
- Any unused or illegal state encoding → IDLE on the next edge.
- Counter never wraps: it is cleared on every state change and bounded by the dwell parameters.

Optional Feature:
Macro RACE_LIGHTS_ABORT_EN.
- Defined: START=0 sampled in S_RED or S_YELLOW → IDLE at that edge; all lamps off; counter cleared.
- Undefined: START is ignored in S_RED and S_YELLOW. The sequence always completes to GREEN, then exits as soon as START=0 is sampled in S_GREEN. If START is already low on reaching S_GREEN, GREEN is lit for exactly 1 cycle.

Test Plan:
- Reset: clock period 10 ns; Reset=1 for the first edge with START=1 → all outputs 0 while reset is active, and the FSM holds IDLE.
- Basic sequence (defaults): Reset released, START=1 held, first active edge k → RED for 2 cycles, YELLOW for 2 cycles, GREEN from edge k+4 and held through a 70 ns run. One-hot checked every cycle.
- Release in GREEN: after GREEN is lit, drop START → all outputs 0 after the next edge. Raise START again → RED after the following edge.
- Parameter override: RED_CYCLES=3, YELLOW_CYCLES=1 → RED high exactly 3 cycles, YELLOW exactly 1, then GREEN.
- Mid-sequence reset: assert Reset during S_YELLOW → outputs 000 after that edge. Release with START=1 → the sequence restarts at RED.
- Abort: pulse START low for 1 cycle during S_RED.
  - With RACE_LIGHTS_ABORT_EN: outputs go to 000 and IDLE.
  - Without it: the sequence continues to GREEN unaffected.

Source files
------------

// File: rtl/race_lights_controller_if.sv
// Start/lamp bundle between the start-button conditioning logic, the light
// sequencer and the lamp drivers.
interface race_lights_controller_if;
  logic start;
  logic red;
  logic yellow;
  logic green;

  modport master (
    output start,
    input  red,
    input  yellow,
    input  green
  );

  modport slave (
    input  start,
    output red,
    output yellow,
    output green
  );
endinterface

// File: rtl/race_lights_controller.sv
// Drag-race light sequencer: IDLE -> RED -> YELLOW -> GREEN, held until start drops.
// Optional macro RACE_LIGHTS_ABORT_EN: start low during RED/YELLOW aborts to IDLE.
module race_lights_controller #(
  parameter int unsigned RED_CYCLES    = 2,
  parameter int unsigned YELLOW_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input logic                      clk_i,
  input logic                      rst_i,
  race_lights_controller_if.slave  lights_if
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    S_RED    = 2'd1,
    S_YELLOW = 2'd2,
    S_GREEN  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             red_q, yellow_q, green_q;
  logic             red_d, yellow_d, green_d;

  // State, dwell counter and lamp registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      red_q    <= 1'b0;
      yellow_q <= 1'b0;
      green_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
    end
  end

  // Next-state and dwell counting; the counter is cleared on every transition
  always_comb begin
    state_d = IDLE;
    cnt_d   = CNT_ZERO;
    case (state_q)
      IDLE: begin
        if (lights_if.start) begin
          state_d = S_RED;
        end else begin
          state_d = IDLE;
        end
      end
      S_RED: begin
`ifdef RACE_LIGHTS_ABORT_EN
        if (!lights_if.start) begin
          state_d = IDLE;
        end else if (cnt_q == RED_LAST) begin
          state_d = S_YELLOW;
        end else begin
          state_d = S_RED;
          cnt_d   = cnt_q + CNT_ONE;
        end
`else
        if (cnt_q == RED_LAST) begin
          state_d = S_YELLOW;
        end else begin
          state_d = S_RED;
          cnt_d   = cnt_q + CNT_ONE;
        end
`endif
      end
      S_YELLOW: begin
`ifdef RACE_LIGHTS_ABORT_EN
        if (!lights_if.start) begin
          state_d = IDLE;
        end else if (cnt_q == YELLOW_LAST) begin
          state_d = S_GREEN;
        end else begin
          state_d = S_YELLOW;
          cnt_d   = cnt_q + CNT_ONE;
        end
`else
        if (cnt_q == YELLOW_LAST) begin
          state_d = S_GREEN;
        end else begin
          state_d = S_YELLOW;
          cnt_d   = cnt_q + CNT_ONE;
        end
`endif
      end
      S_GREEN: begin
        if (lights_if.start) begin
          state_d = S_GREEN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lamps are registered alongside the state so they track it without a START path
  always_comb begin
    red_d    = 1'b0;
    yellow_d = 1'b0;
    green_d  = 1'b0;
    case (state_d)
      S_RED:    red_d    = 1'b1;
      S_YELLOW: yellow_d = 1'b1;
      S_GREEN:  green_d  = 1'b1;
      default: begin
        red_d    = 1'b0;
        yellow_d = 1'b0;
        green_d  = 1'b0;
      end
    endcase
  end

  assign lights_if.red    = red_q;
  assign lights_if.yellow = yellow_q;
  assign lights_if.green  = green_q;

endmodule

// File: tb/tb_race_lights_controller.sv
// Randomised self-checking bench for race_lights_controller: default and
// RED=3/YELLOW=1 instances checked against an elapsed-time lamp model.
module tb_race_lights_controller;

  logic clk;
  logic rst_s;
  int   vec_cnt;
  int   err_cnt;

  // Model: per instance, whether a sequence is running and cycles elapsed in it
  int   r_p [2];
  int   y_p [2];
  bit   m_run [2];
  int   m_t [2];

  race_lights_controller_if lif0 ();
  race_lights_controller_if lif1 ();

  race_lights_controller dut_def (
    .clk_i     (clk),
    .rst_i     (rst_s),
    .lights_if (lif0.slave)
  );

  race_lights_controller #(
    .RED_CYCLES    (3),
    .YELLOW_CYCLES (1),
    .CNT_W         (4)
  ) dut_ovr (
    .clk_i     (clk),
    .rst_i     (rst_s),
    .lights_if (lif1.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    vec_cnt++;
    if (obs !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [2:0] model_lamps(input int d);
    if (!m_run[d])                 return 3'b000;
    if (m_t[d] < r_p[d])           return 3'b100;
    if (m_t[d] < r_p[d] + y_p[d])  return 3'b010;
    return 3'b001;
  endfunction

  task automatic model_edge(input bit rst, input bit st);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_run[d] = 1'b0;
        m_t[d]   = 0;
      end else if (!m_run[d]) begin
        if (st) begin
          m_run[d] = 1'b1;
          m_t[d]   = 0;
        end
      end else if (m_t[d] >= r_p[d] + y_p[d]) begin
        if (!st) m_run[d] = 1'b0;
      end else begin
`ifdef RACE_LIGHTS_ABORT_EN
        if (!st) m_run[d] = 1'b0;
        else     m_t[d]   = m_t[d] + 1;
`else
        m_t[d] = m_t[d] + 1;
`endif
      end
    end
  endtask

  task automatic step(input bit rst, input bit st);
    logic [2:0] o0, o1;
    rst_s      = rst;
    lif0.start = st;
    lif1.start = st;
    @(posedge clk);
    model_edge(rst, st);
    @(negedge clk);
    o0 = {lif0.red, lif0.yellow, lif0.green};
    o1 = {lif1.red, lif1.yellow, lif1.green};
    check_val("lamps_def", o0, model_lamps(0));
    check_val("lamps_ovr", o1, model_lamps(1));
    check_val("onehot_def", {2'b00, ($countones(o0) <= 1)}, 3'b001);
    check_val("onehot_ovr", {2'b00, ($countones(o1) <= 1)}, 3'b001);
  endtask

  initial begin
    vec_cnt    = 0;
    err_cnt    = 0;
    r_p[0] = 2; y_p[0] = 2;
    r_p[1] = 3; y_p[1] = 1;
    m_run[0] = 1'b0; m_run[1] = 1'b0;
    m_t[0] = 0; m_t[1] = 0;
    rst_s      = 1'b1;
    lif0.start = 1'b1;
    lif1.start = 1'b1;

    // Reset with START high, then a held-START run into GREEN
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1);
    // Release in GREEN, then re-arm
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    // Mid-sequence reset during YELLOW of the default instance, restart
    step(1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    // One-cycle START dip during RED
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    // START already low when GREEN is reached
    step(1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0);

    // Random traffic: START mostly held in runs, occasional reset
    for (int i = 0; i < 600; i++) begin
      bit st, rs;
      st = ($urandom_range(0, 99) < 70);
      rs = ($urandom_range(0, 99) < 3);
      step(rs, st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
